clock_reset_ctrl: RTL and testbench
===================================

// Module: clock_reset_ctrl
// PURPOSE
//  Parametrised clock/reset front end between board pins and CPU core. From one fast
//  clock it derives a CPU clock-enable (any integer divisor), a display-refresh
//  enable, debounced front-panel buttons with press pulses, single-step gating and a
//  stretched system reset. Core logic stays on CLK and uses enables, not divided clocks.
// PARAMETERS
//  CPU_DIV      8      CLK cycles per cpu_ce pulse; integer >=2, need not be 2^n
//  REFRESH_DIV  2048   CLK cycles per refresh_ce pulse; integer >=2
//  NBUT         2      number of front-panel buttons
//  DEB_CYCLES   65536  consecutive disagreeing cycles before a button change is accepted
//  RST_BUT      1      button index that triggers a system reset (0..NBUT-1)
//  RST_STRETCH  16     cycles sys_reset stays high after its cause goes away (>=1)
// PORTS
//  CLK         in   1     system clock
//  nRESET      in   1     asynchronous active-low reset
//  nBUT        in   NBUT  raw buttons, active-low, asynchronous to CLK
//  step_mode   in   1     0 = free run, 1 = single-step
//  step_req    in   1     one-cycle request for one cpu_ce (honoured only in step mode)
//  cpu_ce      out  1     one-cycle CPU enable
//  refresh_ce  out  1     one-cycle display-refresh enable
//  but         out  NBUT  debounced button level, active-high (1 = pressed)
//  but_press   out  NBUT  one-cycle pulse on debounced press (0->1 of but)
//  sys_reset   out  1     active-high system reset: async assert, sync deassert
//  step_armed  out  1     a step request is pending
// BEHAVIOUR
//  Reset (nRESET low): cpu_ce=0, refresh_ce=0, but=0, but_press=0, step_armed=0,
//   sys_reset=1, all counters and synchronisers cleared (sync stage = released).
//  Buttons, per bit, independent: 2-flop synchroniser on ~nBUT -> s. Counter dc
//   increments each cycle s!=but, clears to 0 any cycle s==but. When dc==DEB_CYCLES-1
//   and s!=but: but<=s, dc<=0. but_press high exactly the cycle after but goes 0->1.
//   Latency raw edge -> but: 2 sync cycles + DEB_CYCLES cycles. Glitch shorter than
//   DEB_CYCLES: no change and no pulse.
//  Reset stretcher: cause = nRESET low (async) or but[RST_BUT] high. nRESET release
//   passes through a 2-flop synchroniser. While cause holds, sys_reset=1 and stretch
//   counter reloads RST_STRETCH; once cause clears it counts down and sys_reset drops
//   on the cycle it reaches 0 (exactly RST_STRETCH cycles after the last cause cycle).
//   A new cause mid-countdown reloads the counter.
//  CPU prescaler pc: 0..CPU_DIV-1 wrap. Terminal count TC = (pc==CPU_DIV-1).
//   While sys_reset=1: pc held at 0, cpu_ce=0, step_armed cleared, step_req ignored.
//   step_mode=0: cpu_ce=TC (one pulse every CPU_DIV cycles, first on cycle CPU_DIV
//   after sys_reset falls).
//   step_mode=1: step_req while !step_armed sets step_armed; step_req while armed is
//   dropped (no queue). Next TC with step_armed: cpu_ce=1, step_armed<=0 same edge.
//   step_req coinciding with a TC does not fire that TC; it fires the following one.
//   step_mode sampled at TC only; toggling mid-period takes effect at next TC.
//   Leaving step mode with step_armed=1: step_armed clears at that TC, no extra pulse.
//  Refresh prescaler rc: 0..REFRESH_DIV-1 wrap, refresh_ce=(rc==REFRESH_DIV-1).
//   Runs regardless of sys_reset; held at 0 only while nRESET low.
//  All outputs registered except refresh_ce/cpu_ce may decode registered counters.
//  Counter widths $clog2(param); no wrap beyond param-1 under any input sequence.
// TESTING (CPU_DIV=3, REFRESH_DIV=5, DEB_CYCLES=4, RST_STRETCH=3, NBUT=2, RST_BUT=1)
//  1 nRESET low 5 cyc then high -> sys_reset falls 2+3 cyc after release edge;
//    cpu_ce pulses every 3 cyc, first 3 cyc after fall; refresh_ce every 5 cyc.
//  2 nBUT[0] low 3 cyc then high -> but[0] stays 0, no but_press. Held low 10 cyc ->
//    but[0]=1 at 6 cyc after edge, one but_press[0] pulse; release -> but[0]=0, no pulse.
//  3 Debounced press of nBUT[1] mid-run -> sys_reset rises next cycle, cpu_ce stops,
//    sys_reset falls 3 cyc after but[1] returns 0.
//  4 step_mode=1, three step_req 1 cyc apart -> exactly one cpu_ce at next TC;
//    step_req on a TC cycle -> pulse at following TC (3 cyc later).
//  5 step_mode=1 with step_armed=1, switch to 0 -> no extra pulse; free run resumes
//    at next TC period.
//  6 Assert nRESET mid step/debounce -> all outputs to reset values immediately
//    (async), counters 0 on release.

Source files
------------

// File: rtl/clock_reset_ctrl.sv
// Clock/reset front end: CPU and refresh clock-enables, debounced buttons with press
// pulses, single-step gating and a stretched system reset, all on the single fast clock.
module clock_reset_ctrl #(
   parameter int CPU_DIV     = 8,
   parameter int REFRESH_DIV = 2048,
   parameter int NBUT        = 2,
   parameter int DEB_CYCLES  = 65536,
   parameter int RST_BUT     = 1,
   parameter int RST_STRETCH = 16
) (
   input  logic            CLK,
   input  logic            nRESET,
   input  logic [NBUT-1:0] nBUT,
   input  logic            step_mode,
   input  logic            step_req,
   output logic            cpu_ce,
   output logic            refresh_ce,
   output logic [NBUT-1:0] but,
   output logic [NBUT-1:0] but_press,
   output logic            sys_reset,
   output logic            step_armed
);

   localparam int PC_W = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
   localparam int RC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int DC_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int RS_W = (RST_STRETCH > 1) ? $clog2(RST_STRETCH) : 1;

   logic [1:0]      rsync_q;
   logic [NBUT-1:0] bsync0_q, bsync1_q;
   logic [NBUT-1:0] but_q, but_d, but_dly_q, press_q;
   logic [DC_W-1:0] dc_q [NBUT];
   logic [DC_W-1:0] dc_d [NBUT];
   logic            sys_q, sys_d;
   logic [RS_W-1:0] st_q, st_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [RC_W-1:0] rc_q, rc_d;
   logic            cpu_q, cpu_d;
   logic            armed_q, armed_d;
   logic            cause, tc, hold;

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         rsync_q <= '0;
      end else begin
         rsync_q <= {rsync_q[0], 1'b1};
      end
   end

   // A button flips only after DEB_CYCLES consecutive cycles of disagreement.
   always_comb begin
      but_d = but_q;
      for (int i = 0; i < NBUT; i++) begin
         dc_d[i] = '0;
         if (bsync1_q[i] != but_q[i]) begin
            if (dc_q[i] == DC_W'(DEB_CYCLES - 1)) begin
               but_d[i] = bsync1_q[i];
            end else begin
               dc_d[i] = dc_q[i] + DC_W'(1);
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         bsync0_q  <= '0;
         bsync1_q  <= '0;
         but_q     <= '0;
         but_dly_q <= '0;
         press_q   <= '0;
         for (int i = 0; i < NBUT; i++) dc_q[i] <= '0;
      end else begin
         bsync0_q  <= ~nBUT;
         bsync1_q  <= bsync0_q;
         but_q     <= but_d;
         but_dly_q <= but_q;
         press_q   <= but_q & ~but_dly_q;
         for (int i = 0; i < NBUT; i++) dc_q[i] <= dc_d[i];
      end
   end

   // Counter holds remaining stretch minus one; sys_q itself marks the countdown.
   assign cause = ~rsync_q[1] | but_q[RST_BUT];

   always_comb begin
      sys_d = sys_q;
      st_d  = st_q;
      if (cause) begin
         sys_d = 1'b1;
         st_d  = RS_W'(RST_STRETCH - 1);
      end else if (sys_q) begin
         if (st_q == '0) sys_d = 1'b0;
         else            st_d  = st_q - RS_W'(1);
      end
   end

   assign tc   = (pc_q == PC_W'(CPU_DIV - 1));
   assign hold = sys_q | sys_d;

   // Holding on sys_d too keeps cpu_ce from firing on the edge sys_reset rises.
   always_comb begin
      pc_d    = tc ? '0 : pc_q + PC_W'(1);
      cpu_d   = 1'b0;
      armed_d = armed_q | (step_mode & step_req);
      if (hold) begin
         pc_d    = '0;
         armed_d = 1'b0;
      end else if (tc) begin
         cpu_d   = step_mode ? armed_q : 1'b1;
         armed_d = step_mode & ~armed_q & step_req;
      end
   end

   assign rc_d = (rc_q == RC_W'(REFRESH_DIV - 1)) ? '0 : rc_q + RC_W'(1);

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         sys_q   <= 1'b1;
         st_q    <= '0;
         pc_q    <= '0;
         rc_q    <= '0;
         cpu_q   <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         sys_q   <= sys_d;
         st_q    <= st_d;
         pc_q    <= pc_d;
         rc_q    <= rc_d;
         cpu_q   <= cpu_d;
         armed_q <= armed_d;
      end
   end

   assign cpu_ce     = cpu_q;
   assign refresh_ce = (rc_q == RC_W'(REFRESH_DIV - 1));
   assign but        = but_q;
   assign but_press  = press_q;
   assign sys_reset  = sys_q;
   assign step_armed = armed_q;

endmodule

// File: tb/tb_clock_reset_ctrl.sv
// Bench for clock_reset_ctrl: an event-time reference model queues per-cycle expected
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_clock_reset_ctrl;

   localparam int CPU_DIV     = 3;
   localparam int REFRESH_DIV = 5;
   localparam int NBUT        = 2;
   localparam int DEB_CYCLES  = 4;
   localparam int RST_BUT     = 1;
   localparam int RST_STRETCH = 3;
   localparam int HMAX        = 8192;

   logic            CLK = 1'b0;
   logic            nRESET;
   logic [NBUT-1:0] nBUT;
   logic            step_mode;
   logic            step_req;
   logic            cpu_ce, refresh_ce, sys_reset, step_armed;
   logic [NBUT-1:0] but, but_press;

   clock_reset_ctrl #(
      .CPU_DIV(CPU_DIV), .REFRESH_DIV(REFRESH_DIV), .NBUT(NBUT),
      .DEB_CYCLES(DEB_CYCLES), .RST_BUT(RST_BUT), .RST_STRETCH(RST_STRETCH)
   ) dut (
      .CLK(CLK), .nRESET(nRESET), .nBUT(nBUT), .step_mode(step_mode),
      .step_req(step_req), .cpu_ce(cpu_ce), .refresh_ce(refresh_ce), .but(but),
      .but_press(but_press), .sys_reset(sys_reset), .step_armed(step_armed)
   );

   initial forever #5 CLK = ~CLK;

   typedef struct packed {
      logic            cpu;
      logic            refr;
      logic [NBUT-1:0] but;
      logic [NBUT-1:0] press;
      logic            sys;
      logic            armed;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   // Reference model state: edges since nRESET release and times of key events.
   int              m_n = 0;
   int              m_last_cause = 0;
   int              m_fall = 0;
   logic [NBUT-1:0] m_but = '0;
   logic [NBUT-1:0] m_but_prev = '0;
   logic            m_sys = 1'b1;
   logic            m_armed = 1'b0;
   logic [NBUT-1:0] m_raw [HMAX];
   logic [NBUT-1:0] m_s   [HMAX];

   always @(posedge CLK) begin : model
      exp_t            e;
      logic [NBUT-1:0] old_but;
      logic            old_sys, new_sys, tc, cause, flip;
      e = '0;
      if (!nRESET) begin
         m_n = 0; m_last_cause = 0; m_fall = 0;
         m_but = '0; m_but_prev = '0; m_sys = 1'b1; m_armed = 1'b0;
         e.sys = 1'b1;
      end else begin
         m_n = m_n + 1;
         m_raw[m_n % HMAX] = ~nBUT;
         // Synchronised level seen at edge n is the pin sampled two edges earlier.
         m_s[m_n % HMAX] = (m_n >= 3) ? m_raw[(m_n - 2) % HMAX] : '0;
         old_but = m_but;
         old_sys = m_sys;
         for (int b = 0; b < NBUT; b++) begin
            if (m_n >= DEB_CYCLES) begin
               flip = 1'b1;
               for (int k = 0; k < DEB_CYCLES; k++)
                  if (m_s[(m_n - k) % HMAX][b] == old_but[b]) flip = 1'b0;
               if (flip) m_but[b] = ~old_but[b];
            end
         end
         e.press    = old_but & ~m_but_prev;
         m_but_prev = old_but;
         cause = (m_n <= 2) || old_but[RST_BUT];
         if (cause) m_last_cause = m_n;
         new_sys = (m_n - m_last_cause) < RST_STRETCH;
         if (old_sys && !new_sys) m_fall = m_n;
         tc = !old_sys && !new_sys && (m_n > m_fall) && (((m_n - m_fall) % CPU_DIV) == 0);
         e.cpu = tc && (step_mode ? m_armed : 1'b1);
         if (old_sys || new_sys) m_armed = 1'b0;
         else if (tc)            m_armed = step_mode && !m_armed && step_req;
         else                    m_armed = m_armed || (step_mode && step_req);
         m_sys   = new_sys;
         e.refr  = ((m_n % REFRESH_DIV) == REFRESH_DIV - 1);
         e.but   = m_but;
         e.sys   = m_sys;
         e.armed = m_armed;
      end
      exp_q.push_back(e);
   end

   task automatic chk1(input string name, input logic act, input logic expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, expv);
      end
   endtask

   task automatic chkv(input string name, input logic [NBUT-1:0] act, input logic [NBUT-1:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, expv);
      end
   endtask

   always @(negedge CLK) begin : monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         // Reset asserted since the last edge must already show on the outputs.
         if (!nRESET) begin
            e = '0;
            e.sys = 1'b1;
         end
         chk1("cpu_ce",     cpu_ce,     e.cpu);
         chk1("refresh_ce", refresh_ce, e.refr);
         chkv("but",        but,        e.but);
         chkv("but_press",  but_press,  e.press);
         chk1("sys_reset",  sys_reset,  e.sys);
         chk1("step_armed", step_armed, e.armed);
      end
   end

   task automatic tick(input int k);
      repeat (k) @(posedge CLK);
      #1;
   endtask

   int hold [NBUT];

   initial begin
      nRESET = 1'b0; nBUT = '1; step_mode = 1'b0; step_req = 1'b0;
      tick(5);
      nRESET = 1'b1;
      tick(30);

      nBUT[0] = 1'b0; tick(3);
      nBUT[0] = 1'b1; tick(10);
      nBUT[0] = 1'b0; tick(10);
      nBUT[0] = 1'b1; tick(10);

      nBUT[1] = 1'b0; tick(8);
      nBUT[1] = 1'b1; tick(20);

      step_mode = 1'b1; tick(6);
      step_req = 1'b1; tick(3);
      step_req = 1'b0; tick(10);
      for (int i = 0; i < 3 * CPU_DIV; i++) begin
         if (!m_sys && (((m_n + 1 - m_fall) % CPU_DIV) == 0)) break;
         tick(1);
      end
      step_req = 1'b1; tick(1);
      step_req = 1'b0; tick(8);

      step_req = 1'b1; tick(1);
      step_req = 1'b0; step_mode = 1'b0; tick(12);

      step_mode = 1'b1;
      step_req = 1'b1; tick(1);
      step_req = 1'b0; nBUT[0] = 1'b0; tick(3);
      nRESET = 1'b0; tick(4);
      nRESET = 1'b1; nBUT[0] = 1'b1; step_mode = 1'b0; tick(20);

      for (int b = 0; b < NBUT; b++) hold[b] = 0;
      for (int c = 0; c < 2500; c++) begin
         for (int b = 0; b < NBUT; b++) begin
            if (hold[b] == 0) begin
               nBUT[b] = ($urandom_range(0, 1) == 1);
               hold[b] = $urandom_range(1, 12);
            end else begin
               hold[b] = hold[b] - 1;
            end
         end
         step_req = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 39) == 0) step_mode = ~step_mode;
         if ($urandom_range(0, 399) == 0) begin
            nRESET = 1'b0;
            tick($urandom_range(1, 3));
            nRESET = 1'b1;
         end
         tick(1);
      end

      step_req = 1'b0;
      tick(5);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
